// File: rtl/fp_min_pipe.sv
// Two-stage pipelined IEEE-754 minimum with valid/ready on both sides.
// Optional macro FP_MIN_SNAN_FLAG_EN adds out_invalid (signalling-NaN operand seen).
module fp_min_pipe #(
   parameter  int SIGN_W = 1,
   parameter  int EXPO_W = 8,
   parameter  int MANT_W = 23,
   localparam int FP_W   = SIGN_W + EXPO_W + MANT_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_vld,
   output logic            in_rdy,
   input  logic [FP_W-1:0] in_a,
   input  logic [FP_W-1:0] in_b,
   output logic            out_vld,
   input  logic            out_rdy,
   output logic [FP_W-1:0] out_res,
   output logic            out_inf_pos,
   output logic            out_inf_neg,
   output logic            out_sel_b
`ifdef FP_MIN_SNAN_FLAG_EN
   ,
   output logic            out_invalid
`endif
);

   localparam int MAG_W = EXPO_W + MANT_W;

   function automatic logic f_is_zero(input logic [EXPO_W-1:0] e, input logic [MANT_W-1:0] m);
      return (e == {EXPO_W{1'b0}}) && (m == {MANT_W{1'b0}});
   endfunction

   function automatic logic f_is_inf(input logic [EXPO_W-1:0] e, input logic [MANT_W-1:0] m);
      return (e == {EXPO_W{1'b1}}) && (m == {MANT_W{1'b0}});
   endfunction

   function automatic logic f_is_nan(input logic [EXPO_W-1:0] e, input logic [MANT_W-1:0] m);
      return (e == {EXPO_W{1'b1}}) && (m != {MANT_W{1'b0}});
   endfunction

`ifdef FP_MIN_SNAN_FLAG_EN
   function automatic logic f_is_snan(input logic [EXPO_W-1:0] e, input logic [MANT_W-1:0] m);
      return f_is_nan(e, m) && !m[MANT_W-1];
   endfunction
`endif

   logic              r_s1_vld;
   logic              r_s1_a_sign, r_s1_b_sign;
   logic [EXPO_W-1:0] r_s1_a_expo, r_s1_b_expo;
   logic [MANT_W-1:0] r_s1_a_mant, r_s1_b_mant;
   logic              r_s1_a_zero, r_s1_b_zero;
   logic              r_s1_a_inf,  r_s1_b_inf;
   logic              r_s1_a_nan,  r_s1_b_nan;
`ifdef FP_MIN_SNAN_FLAG_EN
   logic              r_s1_snan;
   logic              r_s2_invalid;
`endif

   logic              r_s2_vld;
   logic [FP_W-1:0]   r_s2_res;
   logic              r_s2_inf_pos;
   logic              r_s2_inf_neg;
   logic              r_s2_sel_b;

   logic              w_s1_adv;
   logic              w_s2_adv;
   logic [MAG_W-1:0]  w_a_mag, w_b_mag;
   logic              w_sel_b;
   logic              w_nan_res;
   logic [FP_W-1:0]   w_res;
   logic              w_inf_pos;
   logic              w_inf_neg;

   // Pipeline advance: a stage moves when empty or when the stage after it moves.
   always_comb begin
      w_s2_adv = !r_s2_vld || out_rdy;
      w_s1_adv = !r_s1_vld || w_s2_adv;
   end

   assign in_rdy = w_s1_adv;

   // Stage 1: unpack and classify both operands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_vld    <= 1'b0;
         r_s1_a_sign <= 1'b0;
         r_s1_b_sign <= 1'b0;
         r_s1_a_expo <= '0;
         r_s1_b_expo <= '0;
         r_s1_a_mant <= '0;
         r_s1_b_mant <= '0;
         r_s1_a_zero <= 1'b0;
         r_s1_b_zero <= 1'b0;
         r_s1_a_inf  <= 1'b0;
         r_s1_b_inf  <= 1'b0;
         r_s1_a_nan  <= 1'b0;
         r_s1_b_nan  <= 1'b0;
`ifdef FP_MIN_SNAN_FLAG_EN
         r_s1_snan   <= 1'b0;
`endif
      end else begin
         if (w_s1_adv) begin
            r_s1_vld <= in_vld;
         end
         if (w_s1_adv && in_vld) begin
            r_s1_a_sign <= in_a[FP_W-1];
            r_s1_b_sign <= in_b[FP_W-1];
            r_s1_a_expo <= in_a[MAG_W-1:MANT_W];
            r_s1_b_expo <= in_b[MAG_W-1:MANT_W];
            r_s1_a_mant <= in_a[MANT_W-1:0];
            r_s1_b_mant <= in_b[MANT_W-1:0];
            r_s1_a_zero <= f_is_zero(in_a[MAG_W-1:MANT_W], in_a[MANT_W-1:0]);
            r_s1_b_zero <= f_is_zero(in_b[MAG_W-1:MANT_W], in_b[MANT_W-1:0]);
            r_s1_a_inf  <= f_is_inf(in_a[MAG_W-1:MANT_W], in_a[MANT_W-1:0]);
            r_s1_b_inf  <= f_is_inf(in_b[MAG_W-1:MANT_W], in_b[MANT_W-1:0]);
            r_s1_a_nan  <= f_is_nan(in_a[MAG_W-1:MANT_W], in_a[MANT_W-1:0]);
            r_s1_b_nan  <= f_is_nan(in_b[MAG_W-1:MANT_W], in_b[MANT_W-1:0]);
`ifdef FP_MIN_SNAN_FLAG_EN
            r_s1_snan   <= f_is_snan(in_a[MAG_W-1:MANT_W], in_a[MANT_W-1:0]) ||
                           f_is_snan(in_b[MAG_W-1:MANT_W], in_b[MANT_W-1:0]);
`endif
         end
      end
   end

   // Stage 2 selection: sign-magnitude order, NaN operands lose, ties go to A.
   always_comb begin
      w_a_mag   = {r_s1_a_expo, r_s1_a_mant};
      w_b_mag   = {r_s1_b_expo, r_s1_b_mant};
      w_sel_b   = 1'b0;
      w_nan_res = 1'b0;
      if (r_s1_a_nan && r_s1_b_nan) begin
         w_nan_res = 1'b1;
      end else if (r_s1_a_nan) begin
         w_sel_b = 1'b1;
      end else if (r_s1_b_nan) begin
         w_sel_b = 1'b0;
      end else if (r_s1_a_zero && r_s1_b_zero) begin
         w_sel_b = !r_s1_a_sign && r_s1_b_sign;
      end else if (r_s1_a_sign != r_s1_b_sign) begin
         w_sel_b = r_s1_b_sign;
      end else if (!r_s1_a_sign) begin
         w_sel_b = (w_b_mag < w_a_mag);
      end else begin
         w_sel_b = (w_b_mag > w_a_mag);
      end
   end

   // Result assembly and infinity flags from the chosen operand.
   always_comb begin
      w_res     = {r_s1_a_sign, r_s1_a_expo, r_s1_a_mant};
      w_inf_pos = 1'b0;
      w_inf_neg = 1'b0;
      if (w_nan_res) begin
         w_res = {1'b0, {EXPO_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
      end else if (w_sel_b) begin
         w_res     = {r_s1_b_sign, r_s1_b_expo, r_s1_b_mant};
         w_inf_pos = r_s1_b_inf && !r_s1_b_sign;
         w_inf_neg = r_s1_b_inf && r_s1_b_sign;
      end else begin
         w_inf_pos = r_s1_a_inf && !r_s1_a_sign;
         w_inf_neg = r_s1_a_inf && r_s1_a_sign;
      end
   end

   // Stage 2 registers: hold contents while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s2_vld     <= 1'b0;
         r_s2_res     <= '0;
         r_s2_inf_pos <= 1'b0;
         r_s2_inf_neg <= 1'b0;
         r_s2_sel_b   <= 1'b0;
`ifdef FP_MIN_SNAN_FLAG_EN
         r_s2_invalid <= 1'b0;
`endif
      end else begin
         if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
         end
         if (w_s2_adv && r_s1_vld) begin
            r_s2_res     <= w_res;
            r_s2_inf_pos <= w_inf_pos;
            r_s2_inf_neg <= w_inf_neg;
            r_s2_sel_b   <= w_sel_b && !w_nan_res;
`ifdef FP_MIN_SNAN_FLAG_EN
            r_s2_invalid <= r_s1_snan;
`endif
         end
      end
   end

   assign out_vld     = r_s2_vld;
   assign out_res     = r_s2_res;
   assign out_inf_pos = r_s2_inf_pos;
   assign out_inf_neg = r_s2_inf_neg;
   assign out_sel_b   = r_s2_sel_b;
`ifdef FP_MIN_SNAN_FLAG_EN
   assign out_invalid = r_s2_invalid;
`endif

endmodule

// File: tb/tb_fp_min_pipe.sv
// Randomised and directed bench for fp_min_pipe against an ordering-key reference model.
module tb_fp_min_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_vld;
   logic        in_rdy;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        out_vld;
   logic        out_rdy;
   logic [31:0] out_res;
   logic        out_inf_pos;
   logic        out_inf_neg;
   logic        out_sel_b;
   logic        out_invalid;

   int tests;
   int fails;

   typedef struct packed {
      logic [31:0] res;
      logic        sel;
      logic        pos;
      logic        neg;
      logic        inv;
   } exp_t;

   exp_t q[$];

   fp_min_pipe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_res    (out_res),
      .out_inf_pos(out_inf_pos),
      .out_inf_neg(out_inf_neg),
`ifdef FP_MIN_SNAN_FLAG_EN
      .out_invalid(out_invalid),
`endif
      .out_sel_b  (out_sel_b)
   );

`ifndef FP_MIN_SNAN_FLAG_EN
   assign out_invalid = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   function automatic logic is_snan(input logic [31:0] x);
      return is_nan(x) && !x[22];
   endfunction

   // Total order over non-NaN values: -0 sits just below +0.
   function automatic longint okey(input logic [31:0] x);
      longint mag;
      mag = longint'(x[30:0]);
      return x[31] ? (-(2 * mag) - 1) : (2 * mag);
   endfunction

   function automatic exp_t ref_min(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.inv = 1'b0;
`ifdef FP_MIN_SNAN_FLAG_EN
      e.inv = is_snan(a) || is_snan(b);
`endif
      if (is_nan(a) && is_nan(b)) begin
         e.res = 32'h7FC00000;
         e.sel = 1'b0;
      end else if (is_nan(a)) begin
         e.res = b;
         e.sel = 1'b1;
      end else if (is_nan(b)) begin
         e.res = a;
         e.sel = 1'b0;
      end else begin
         e.sel = okey(b) < okey(a);
         e.res = e.sel ? b : a;
      end
      e.pos = (e.res == 32'h7F800000);
      e.neg = (e.res == 32'hFF800000);
      return e;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      logic        s;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
         0: v = {s, 31'd0};
         1: v = {s, 8'hFF, 23'd0};
         2: v = {s, 8'hFF, 1'b1, 22'($urandom)};
         3: v = {s, 8'hFF, 1'b0, 22'($urandom) | 22'd1};
         4: v = {s, 8'h00, 23'($urandom)};
         5: v = {s, 8'h7F + 8'($urandom_range(0, 2)), 23'($urandom_range(0, 3))};
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Scoreboard: record accepted pairs, check every transferred result and stall stability.
   logic        prev_stall;
   logic [35:0] prev_out;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_vld", {31'd0, out_vld}, 32'd1);
            chk("hold_res", out_res, prev_out[35:4]);
            chk("hold_flags", {28'd0, out_inf_pos, out_inf_neg, out_sel_b, out_invalid},
                {28'd0, prev_out[3:0]});
         end
         if (out_vld && out_rdy) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_out: got result %h expected no result", out_res);
            end else begin
               e = q.pop_front();
               chk("sb_res", out_res, e.res);
               chk("sb_sel_b", {31'd0, out_sel_b}, {31'd0, e.sel});
               chk("sb_inf", {30'd0, out_inf_pos, out_inf_neg}, {30'd0, e.pos, e.neg});
               chk("sb_invalid", {31'd0, out_invalid}, {31'd0, e.inv});
            end
         end
         if (in_vld && in_rdy) q.push_back(ref_min(in_a, in_b));
         prev_stall = out_vld && !out_rdy;
         prev_out   = {out_res, out_inf_pos, out_inf_neg, out_sel_b, out_invalid};
      end
   end

   task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                           input logic esel, input logic epos, input logic eneg, input logic einv);
      int w;
      @(posedge clk); #1;
      in_vld = 1'b1; in_a = a; in_b = b;
      w = 0;
      @(negedge clk);
      while (!in_rdy && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("accept", {31'd0, in_rdy}, 32'd1);
      @(posedge clk); #1;
      in_vld = 1'b0;
      @(negedge clk);
      chk("lat_cycle1", {31'd0, out_vld}, 32'd0);
      @(negedge clk);
      chk("lat_cycle2", {31'd0, out_vld}, 32'd1);
      chk("dir_res", out_res, er);
      chk("dir_sel_b", {31'd0, out_sel_b}, {31'd0, esel});
      chk("dir_inf", {30'd0, out_inf_pos, out_inf_neg}, {30'd0, epos, eneg});
`ifdef FP_MIN_SNAN_FLAG_EN
      chk("dir_invalid", {31'd0, out_invalid}, {31'd0, einv});
`else
      if (einv) begin end
`endif
   endtask

   task automatic drain();
      int w;
      in_vld = 1'b0;
      out_rdy = 1'b1;
      w = 0;
      while ((q.size() != 0 || out_vld) && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("drain_empty", q.size(), 32'd0);
   endtask

   task automatic backpressure();
      int acc;
      int first_block;
      int w;
      logic got;
      logic [31:0] bp_a [4];
      logic [31:0] bp_b [4];
      bp_a[0] = 32'h40A00000; bp_b[0] = 32'h40400000;
      bp_a[1] = 32'hC1200000; bp_b[1] = 32'h41200000;
      bp_a[2] = 32'h00000001; bp_b[2] = 32'h00000002;
      bp_a[3] = 32'h3F800000; bp_b[3] = 32'h3F800000;
      acc = 0; first_block = -1; w = 0;
      @(posedge clk); #1;
      out_rdy = 1'b0;
      fork
         begin
            repeat (3) @(posedge clk);
            #1 out_rdy = 1'b1;
         end
         begin
            in_vld = 1'b1; in_a = bp_a[0]; in_b = bp_b[0];
            while (acc < 4 && w < 40) begin
               @(negedge clk);
               got = in_rdy;
               if (!got && first_block < 0) first_block = acc;
               @(posedge clk); #1;
               if (got) acc++;
               if (acc < 4) begin
                  in_a = bp_a[acc]; in_b = bp_b[acc];
               end else begin
                  in_vld = 1'b0;
               end
               w++;
            end
         end
      join
      chk("bp_accepts", acc, 32'd4);
      chk("bp_rdy_drop", first_block, 32'd2);
      drain();
   endtask

   task automatic reset_midflight();
      @(posedge clk); #1;
      out_rdy = 1'b0;
      in_vld = 1'b1; in_a = 32'h41000000; in_b = 32'h40E00000;
      @(posedge clk); #1;
      in_a = 32'hC0000000; in_b = 32'h3F000000;
      @(posedge clk); #1;
      in_vld = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_rdy = 1'b1;
      @(negedge clk);
      chk("rst_mid_vld", {31'd0, out_vld}, 32'd0);
      chk("rst_mid_res", out_res, 32'd0);
      run_pair(32'h40800000, 32'hC0800000, 32'hC0800000, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic random_run();
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         in_vld  = ($urandom_range(0, 3) != 0);
         out_rdy = ($urandom_range(0, 3) != 0);
         in_a    = pick();
         in_b    = ($urandom_range(0, 7) == 0) ? in_a : pick();
      end
      @(posedge clk); #1;
      drain();
   endtask

   initial begin
      tests = 0; fails = 0;
      prev_stall = 1'b0; prev_out = '0;
      rst_n = 1'b0; in_vld = 1'b0; in_a = 32'd0; in_b = 32'd0; out_rdy = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_vld", {31'd0, out_vld}, 32'd0);
      chk("rst_res", out_res, 32'd0);
      chk("rst_flags", {29'd0, out_inf_pos, out_inf_neg, out_sel_b}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", {31'd0, in_rdy}, 32'd1);

      run_pair(32'h3F800000, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);
      run_pair(32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0);
      run_pair(32'hC0000000, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0, 1'b0, 1'b0);
      run_pair(32'h7F800000, 32'hFF800000, 32'hFF800000, 1'b1, 1'b0, 1'b1, 1'b0);
      run_pair(32'h7F800000, 32'h7FC00000, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0);
      run_pair(32'h7FC00000, 32'h40400000, 32'h40400000, 1'b1, 1'b0, 1'b0, 1'b0);
      run_pair(32'hFFC00001, 32'h7FA00000, 32'h7FC00000, 1'b0, 1'b0, 1'b0, 1'b1);
      run_pair(32'h00000003, 32'h00000002, 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0);
      run_pair(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 1'b0);

      backpressure();
      reset_midflight();
      random_run();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
